// File: rtl/mod3_pkg.sv
// Shared definitions for the mod-3 serializer front end: state encoding,
// default word length and the down-counter width helper.
// Optional result path: MOD3_SER_RESULT_EN (DONE state is always encoded).
package mod3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int WIDTH_DEFAULT = 8;

    // Bits needed for a counter that runs WIDTH-1 down to 0.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/mod3_serializer_if.sv
// Word handshake plus serial/FSM-side signals of the mod-3 serializer.
// With MOD3_SER_RESULT_EN defined the interface also carries mod3_in,
// result and result_valid.
interface mod3_serializer_if
    import mod3_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             frame_clr;
    logic             busy;
    logic             fsm_rst;
`ifdef MOD3_SER_RESULT_EN
    logic             mod3_in;
    logic             result;
    logic             result_valid;

    modport master (
        output in_data, in_valid, mod3_in,
        input  in_ready, bit_out, bit_valid, frame_clr, busy, fsm_rst,
        input  result, result_valid
    );

    modport slave (
        input  in_data, in_valid, mod3_in,
        output in_ready, bit_out, bit_valid, frame_clr, busy, fsm_rst,
        output result, result_valid
    );
`else
    modport master (
        output in_data, in_valid,
        input  in_ready, bit_out, bit_valid, frame_clr, busy, fsm_rst
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, bit_out, bit_valid, frame_clr, busy, fsm_rst
    );
`endif
endinterface

// File: rtl/piso_shreg.sv
// Parallel-in serial-out shift register, MSB first. Load has priority
// over shift; the MSB tap presents the next bit to send.
module piso_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);
    logic [WIDTH-1:0] sreg;

    // Capture a new word or move the remaining bits one place toward the MSB.
    // NOTE: a plain data register like this could skip reset; it is reset
    // anyway so no stale word is ever visible on the tap after rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/mod3_serializer.sv
// Parallel-to-serial front end for the divisible-by-3 bit-serial FSM.
// Accepts a word, clears the FSM for one cycle, then shifts the word out
// MSB first. Define MOD3_SER_RESULT_EN to add the DONE state and return
// the FSM's verdict as a one-cycle result pulse.
module mod3_serializer
    import mod3_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    mod3_serializer_if.slave  bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            load_en;
    logic            shift_en;
    logic            msb;
    logic            bit_out_q;
    logic            bit_valid_q;
    logic            frame_clr_q;
`ifdef MOD3_SER_RESULT_EN
    logic            result_q;
    logic            result_valid_q;
`endif

    // The shift register is loaded on acceptance and advanced each time a
    // bit is moved from its MSB tap into bit_out.
    assign load_en  = (state == IDLE) && bus.in_valid;
    assign shift_en = (state == CLR) || ((state == SHIFT) && (cnt != '0));

    piso_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (load_en),
        .shift (shift_en),
        .din   (bus.in_data),
        .msb   (msb)
    );

    // Frame sequencer: IDLE -> CLR -> SHIFT (-> DONE) -> IDLE, outputs registered.
    // NOTE: every state and output register uses <= so all of them update
    // together from the values sampled before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_out_q      <= 1'b0;
            bit_valid_q    <= 1'b0;
            frame_clr_q    <= 1'b0;
`ifdef MOD3_SER_RESULT_EN
            result_q       <= 1'b0;
            result_valid_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef MOD3_SER_RESULT_EN
                    result_valid_q <= 1'b0;
`endif
                    if (bus.in_valid) begin
                        frame_clr_q <= 1'b1;
                        state       <= CLR;
                    end
                end
                CLR: begin
                    frame_clr_q <= 1'b0;
                    cnt         <= CW'(WIDTH - 1);
                    bit_out_q   <= msb;
                    bit_valid_q <= 1'b1;
                    state       <= SHIFT;
                end
                SHIFT: begin
                    if (cnt == '0) begin
                        bit_out_q   <= 1'b0;
                        bit_valid_q <= 1'b0;
`ifdef MOD3_SER_RESULT_EN
                        state       <= DONE;
`else
                        state       <= IDLE;
`endif
                    end else begin
                        cnt       <= cnt - CW'(1);
                        bit_out_q <= msb;
                    end
                end
`ifdef MOD3_SER_RESULT_EN
                DONE: begin
                    // The FSM output now reflects the whole word.
                    result_q       <= bus.mod3_in;
                    result_valid_q <= 1'b1;
                    state          <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.bit_out   = bit_out_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.frame_clr = frame_clr_q;
    // frame_clr comes straight from a flop, so this reset is glitch-free.
    assign bus.fsm_rst   = rst | frame_clr_q;
`ifdef MOD3_SER_RESULT_EN
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
`endif

endmodule
